// File: rtl/imem_arb.sv
// Instruction-memory arbiter: shares a single-port synchronous memory between
// the fetch path and a loader/debug port, tracks read responses and drops flushed fetches.
module imem_arb #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          flush,
    output logic          stall_o,
    input  logic          l_req,
    input  logic          l_we,
    input  logic          l_lock,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic {ARB, LOCK} state_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    state_t     state, state_nxt;
    logic [3:0] wait_cnt, wait_nxt;
    logic       resp_f, resp_l, kill;

    // NOTE: every signal gets a default at the top of the block so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        f_gnt     = 1'b0;
        l_gnt     = 1'b0;
        state_nxt = state;
        unique case (state)
            ARB: begin
                if (l_req && wait_cnt == MAX_W) l_gnt = 1'b1;
                else if (f_req && !flush)       f_gnt = 1'b1;
                else if (l_req)                 l_gnt = 1'b1;
                if (l_gnt && l_lock) state_nxt = LOCK;
            end
            LOCK: begin
                // The release cycle is still owned by the loader.
                l_gnt = l_req;
                if (!l_lock) state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end

    always_comb begin
        wait_nxt = wait_cnt;
        if (!l_req || l_gnt)    wait_nxt = '0;
        else if (wait_cnt != MAX_W) wait_nxt = wait_cnt + 4'd1;
    end

    assign m_en    = f_gnt | l_gnt;
    assign m_we    = l_gnt & l_we;
    assign m_addr  = l_gnt ? l_addr : (f_gnt ? f_addr : '0);
    assign m_wdata = l_gnt ? l_wdata : '0;
    assign stall_o = f_req & ~f_gnt;

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ARB;
            wait_cnt <= '0;
            resp_f   <= 1'b0;
            resp_l   <= 1'b0;
            kill     <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            resp_f   <= f_gnt;
            resp_l   <= l_gnt & ~l_we;
            kill     <= f_gnt & flush;
        end
    end

    assign f_rvalid = resp_f & ~flush & ~kill;
    assign l_rvalid = resp_l;
    assign f_rdata  = m_rdata;
    assign l_rdata  = m_rdata;

endmodule

// File: tb/tb_imem_arb.sv
// Directed bench for imem_arb with a word=address memory model.
module tb_imem_arb;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          f_req, flush, l_req, l_we, l_lock;
    logic [AW-1:0] f_addr, l_addr;
    logic [DW-1:0] l_wdata;
    logic          f_gnt, f_rvalid, stall_o, l_gnt, l_rvalid, m_en, m_we;
    logic [DW-1:0] f_rdata, l_rdata, m_wdata, m_rdata;
    logic [AW-1:0] m_addr;

    int total = 0;
    int bad   = 0;

    imem_arb #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .clk(clk), .rstn(rstn),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .flush(flush), .stall_o(stall_o),
        .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: read data equals the address, one cycle after the read.
    always_ff @(posedge clk) begin
        if (m_en && !m_we) m_rdata <= m_addr;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Apply inputs just after a rising edge and settle to mid-cycle for checks.
    task automatic cyc(input logic fr, input logic [AW-1:0] fa, input logic fl,
                       input logic lr, input logic lw, input logic lk,
                       input logic [AW-1:0] la, input logic [DW-1:0] ld);
        @(posedge clk);
        #1;
        f_req = fr; f_addr = fa; flush = fl;
        l_req = lr; l_we = lw; l_lock = lk; l_addr = la; l_wdata = ld;
        #3;
    endtask

    initial begin
        rstn = 1'b0;
        f_req = 0; f_addr = '0; flush = 0; l_req = 0; l_we = 0; l_lock = 0;
        l_addr = '0; l_wdata = '0;
        #2;
        check("rst_f_gnt",    32'(f_gnt), 0);
        check("rst_l_gnt",    32'(l_gnt), 0);
        check("rst_m_en",     32'(m_en), 0);
        check("rst_stall",    32'(stall_o), 0);
        check("rst_f_rvalid", 32'(f_rvalid), 0);
        check("rst_l_rvalid", 32'(l_rvalid), 0);
        check("rst_wait",     32'(dut.wait_cnt), 0);
        @(posedge clk); #1 rstn = 1'b1;

        // Continuous fetch 0x0, 0x4, 0x8
        cyc(1, 32'h0, 0, 0, 0, 0, 0, 0);
        check("cf0_gnt", 32'(f_gnt), 1); check("cf0_stall", 32'(stall_o), 0);
        check("cf0_maddr", m_addr, 32'h0); check("cf0_rv", 32'(f_rvalid), 0);
        cyc(1, 32'h4, 0, 0, 0, 0, 0, 0);
        check("cf1_gnt", 32'(f_gnt), 1); check("cf1_rv", 32'(f_rvalid), 1);
        check("cf1_rdata", f_rdata, 32'h0); check("cf1_maddr", m_addr, 32'h4);
        cyc(1, 32'h8, 0, 0, 0, 0, 0, 0);
        check("cf2_gnt", 32'(f_gnt), 1); check("cf2_rv", 32'(f_rvalid), 1);
        check("cf2_rdata", f_rdata, 32'h4); check("cf2_stall", 32'(stall_o), 0);
        cyc(0, 32'h0, 0, 0, 0, 0, 0, 0);
        check("cf3_rv", 32'(f_rvalid), 1); check("cf3_rdata", f_rdata, 32'h8);
        check("cf3_gnt", 32'(f_gnt), 0); check("cf3_men", 32'(m_en), 0);
        check("cf3_maddr", m_addr, 32'h0);

        // Fetch vs loader starvation: fetch wins 4 times, loader forced on the 5th
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'h20, 0, 1, 0, 0, 32'h200, 0);
            check($sformatf("st%0d_fgnt", i), 32'(f_gnt), 1);
            check($sformatf("st%0d_lgnt", i), 32'(l_gnt), 0);
            check($sformatf("st%0d_wait", i), 32'(dut.wait_cnt), 32'(i));
        end
        cyc(1, 32'h20, 0, 1, 0, 0, 32'h200, 0);
        check("st4_lgnt", 32'(l_gnt), 1); check("st4_fgnt", 32'(f_gnt), 0);
        check("st4_stall", 32'(stall_o), 1); check("st4_maddr", m_addr, 32'h200);
        check("st4_wait", 32'(dut.wait_cnt), 4); check("st4_frv", 32'(f_rvalid), 1);
        check("st4_mwe", 32'(m_we), 0);

        // Fetch 0x10 at N; flush at N+1 with a loader read; new PC 0x40 at N+2
        cyc(1, 32'h10, 0, 0, 0, 0, 0, 0);
        check("n_lrv", 32'(l_rvalid), 1); check("n_lrdata", l_rdata, 32'h200);
        check("n_frv", 32'(f_rvalid), 0); check("n_fgnt", 32'(f_gnt), 1);
        check("n_wait", 32'(dut.wait_cnt), 0);
        cyc(1, 32'h14, 1, 1, 0, 0, 32'h300, 0);
        check("n1_fgnt", 32'(f_gnt), 0); check("n1_frv", 32'(f_rvalid), 0);
        check("n1_stall", 32'(stall_o), 1); check("n1_lgnt", 32'(l_gnt), 1);
        check("n1_maddr", m_addr, 32'h300);
        cyc(1, 32'h40, 0, 0, 0, 0, 0, 0);
        check("n2_fgnt", 32'(f_gnt), 1); check("n2_maddr", m_addr, 32'h40);
        check("n2_frv", 32'(f_rvalid), 0); check("n2_lrv", 32'(l_rvalid), 1);
        check("n2_lrdata", l_rdata, 32'h300);
        cyc(0, 32'h0, 0, 0, 0, 0, 0, 0);
        check("n3_frv", 32'(f_rvalid), 1); check("n3_frdata", f_rdata, 32'h40);
        check("n3_lrv", 32'(l_rvalid), 0);

        // Locked loader burst of 3 writes, fetch pending from the second write on
        cyc(0, 32'h0, 0, 1, 1, 1, 32'h100, 32'hA0);
        check("lk0_lgnt", 32'(l_gnt), 1); check("lk0_mwe", 32'(m_we), 1);
        check("lk0_maddr", m_addr, 32'h100); check("lk0_wdata", m_wdata, 32'hA0);
        cyc(1, 32'h50, 0, 1, 1, 1, 32'h104, 32'hA1);
        check("lk1_fgnt", 32'(f_gnt), 0); check("lk1_stall", 32'(stall_o), 1);
        check("lk1_mwe", 32'(m_we), 1); check("lk1_maddr", m_addr, 32'h104);
        check("lk1_lrv", 32'(l_rvalid), 0);
        cyc(1, 32'h50, 0, 1, 1, 1, 32'h108, 32'hA2);
        check("lk2_fgnt", 32'(f_gnt), 0); check("lk2_stall", 32'(stall_o), 1);
        check("lk2_mwe", 32'(m_we), 1); check("lk2_wdata", m_wdata, 32'hA2);
        cyc(1, 32'h50, 0, 0, 0, 0, 0, 0);
        check("lk3_fgnt", 32'(f_gnt), 0); check("lk3_stall", 32'(stall_o), 1);
        check("lk3_men", 32'(m_en), 0); check("lk3_lrv", 32'(l_rvalid), 0);
        cyc(1, 32'h50, 0, 0, 0, 0, 0, 0);
        check("lk4_fgnt", 32'(f_gnt), 1); check("lk4_stall", 32'(stall_o), 0);
        check("lk4_maddr", m_addr, 32'h50);

        // Reset pulsed the cycle after a fetch grant
        cyc(1, 32'h60, 0, 0, 0, 0, 0, 0);
        check("r0_frv", 32'(f_rvalid), 1); check("r0_frdata", f_rdata, 32'h50);
        @(posedge clk); #1;
        rstn = 1'b0; f_req = 0;
        #3;
        check("r1_frv", 32'(f_rvalid), 0); check("r1_lrv", 32'(l_rvalid), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        #3;
        check("r2_frv", 32'(f_rvalid), 0); check("r2_lrv", 32'(l_rvalid), 0);
        cyc(0, 32'h0, 0, 0, 0, 0, 0, 0);
        check("r3_frv", 32'(f_rvalid), 0); check("r3_men", 32'(m_en), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_arb.md
# imem_arb

Arbiter and sequencer for the single-port synchronous instruction memory. It shares the memory between the fetch path (PC/next-PC logic) and a program-loader/debug port. It returns read data to the winning requester one cycle after grant and drives the fetch stall. It also discards in-flight fetch responses on a jump or branch flush, so stale instructions never reach decode.

## Interface
- AW, 32, address width (byte address)
- DW, 32, data width
- MAX_WAIT, 4, maximum number of consecutive cycles the loader can be denied before it is forced to win (1..15)

- clk  in  1  core clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- f_req  in  1  fetch request (level, held by fetch side until granted)
- f_addr  in  AW  fetch PC
- f_gnt  out  1  fetch granted this cycle (combinational)
- f_rvalid  out  1  fetch data valid (registered)
- f_rdata  out  DW  fetched instruction
- flush  in  1  OR of jump/branch flush; kills fetch grant and fetch response
- stall_o  out  1  f_req & ~f_gnt, fed to PC hold
- l_req  in  1  loader request
- l_we  in  1  loader write enable
- l_lock  in  1  loader keeps ownership while asserted (burst)
- l_addr  in  AW  loader address
- l_wdata  in  DW  loader write data
- l_gnt  out  1  loader granted this cycle (combinational)
- l_rvalid  out  1  loader read data valid (registered, reads only)
- l_rdata  out  DW  loader read data
- m_en  out  1  memory access enable
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid one cycle after m_en & ~m_we

## Operation
- FSM states:
  - ARB: per-cycle arbitration.
  - LOCK: loader owns the memory.
- ARB grant rule, in order:
  1. If l_req and wait_cnt==MAX_WAIT, grant the loader.
  2. Else if f_req and ~flush, grant fetch.
  3. Else if l_req, grant the loader.
  4. Else idle.
- Transitions:
  - ARB→LOCK when the loader is granted with l_lock=1.
  - LOCK→ARB on the first cycle with l_lock=0. That cycle is still arbitrated as LOCK, so the loader is granted if l_req=1.
  - In LOCK, f_gnt=0 always.
- wait_cnt:
  - +1 when l_req & ~l_gnt.
  - Cleared on l_gnt or ~l_req.
  - Saturates at MAX_WAIT.
- Memory drive:
  - m_en = f_gnt|l_gnt.
  - m_addr/m_wdata/m_we are muxed from the winner.
  - m_we = l_gnt & l_we.
  - When idle, m_addr=0, m_wdata=0, m_we=0.
- Response tracking:
  - Registers resp_f and resp_l are set in the cycle after a read grant to the respective side.
  - f_rvalid = resp_f & ~flush & ~kill. kill is set when flush is asserted in the grant cycle; this cannot occur because grant is blocked, but it is guarded anyway.
  - l_rvalid = resp_l.
  - f_rdata and l_rdata both mirror m_rdata; they are valid only when the respective rvalid is high.
- Writes produce no response.
- Exactly one of f_gnt/l_gnt is high at any time, or neither.

## Timing
- Reset values: all registered outputs 0, state=ARB, wait_cnt=0, resp_f=resp_l=0.
- Combinational outputs with no requests present: f_gnt=l_gnt=m_en=stall_o=0.
- Read latency: exactly 1 cycle from grant to rvalid.
- Throughput: one access per cycle. Back-to-back fetches give f_rvalid every cycle.
- Flush in cycle N:
  - f_gnt=0 in N, so stall_o=f_req in N.
  - A fetch response due in N is suppressed.
  - The fetch side presents the new PC in N+1, which is granted normally.
- Flush and loader request in the same cycle: the loader may be granted and its response is unaffected.
- Fetch with no competitor and flush=0: granted the same cycle, stall_o=0.
- Reset asserted mid-operation clears pending responses immediately; no rvalid follows reset release.
- wait_cnt never exceeds MAX_WAIT. With MAX_WAIT=4, the loader waits at most 4 cycles against continuous fetch.

## Test plan
- Continuous fetch, addresses 0x0,0x4,0x8, memory returns word = address: f_gnt=1 every cycle, f_rvalid from the cycle after the first grant, f_rdata 0x0,0x4,0x8, stall_o=0.
- f_req held and l_req held, l_we=0, MAX_WAIT=4: fetch granted 4 cycles, loader granted in cycle 5 (stall_o=1 that cycle), l_rvalid in cycle 6, wait_cnt back to 0.
- Fetch granted at cycle N (addr 0x10), flush=1 at N+1: f_rvalid=0 at N+1, f_gnt=0 at N+1. New addr 0x40 is granted at N+2 and its data returns at N+3.
- Loader l_lock=1 for 3 writes to 0x100..0x108 with f_req=1: m_we=1 for 3 cycles, f_gnt=0, stall_o=1 throughout. Release l_lock → fetch granted the next cycle.
- Reset pulsed low the cycle after a fetch grant: f_rvalid=0, and no rvalid appears after rstn rises.
